quire_window_arbiter: RTL and testbench

- Shares one quire_4_0 accumulator among N decoded-posit<4,0> requester streams.
- Grants whole accumulation windows (sow..eow) atomically using round-robin arbitration.
- Records the owning requester id of each window in a tag FIFO. Tags the quire result (its eow beat) with that id so downstream can steer it.
- Sits between the per-lane posit decoders/multipliers and the quire input; watches the quire output handshake.

---
 rtl/quire_window_arbiter_pkg.sv | 23 ++
 rtl/quire_window_arbiter_if.sv | 46 ++++
 rtl/quire_window_arbiter_tag_fifo.sv | 49 ++++
 rtl/quire_window_arbiter.sv | 124 ++++++++++++
 tb/tb_quire_window_arbiter.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/quire_window_arbiter_pkg.sv
// quire_window_arbiter_pkg: posit<4,0> field widths, arbiter states and the decoded-posit beat type
package quire_window_arbiter_pkg;

    localparam int POSIT_FRAC_W  = 4;
    localparam int POSIT_SCALE_W = 4;
    localparam int QUIRE_W       = 20;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } arb_state_t;

    typedef struct packed {
        logic                     sow;
        logic                     eow;
        logic [POSIT_FRAC_W-1:0]  fraction;
        logic [POSIT_SCALE_W-1:0] scale;
        logic                     sign;
        logic                     zero;
        logic                     nar;
    } posit_beat_t;

endpackage

// File: rtl/quire_window_arbiter_if.sv
// quire_window_arbiter_if: requester, quire-input and quire-result signals of the window arbiter
interface quire_window_arbiter_if #(
    parameter int NB_REQ = 4,
    parameter int ID_W   = 2
);
    logic [NB_REQ-1:0]   req_rts_i;
    logic [NB_REQ-1:0]   req_rtr_o;
    logic [NB_REQ-1:0]   req_sow_i;
    logic [NB_REQ-1:0]   req_eow_i;
    logic [4*NB_REQ-1:0] req_fraction_i;
    logic [4*NB_REQ-1:0] req_scale_i;
    logic [NB_REQ-1:0]   req_sign_i;
    logic [NB_REQ-1:0]   req_zero_i;
    logic [NB_REQ-1:0]   req_NaR_i;
    logic                q_rtr_i;
    logic                q_rts_o;
    logic                q_sow_o;
    logic                q_eow_o;
    logic [3:0]          q_fraction_o;
    logic [3:0]          q_scale_o;
    logic                q_sign_o;
    logic                q_zero_o;
    logic                q_NaR_o;
    logic                res_rts_i;
    logic                res_rtr_i;
    logic                res_eow_i;
    logic [ID_W-1:0]     res_id_o;
    logic                res_id_vld_o;
    logic                busy_o;
    logic                proto_err_o;

    modport slave (
        input  req_rts_i, req_sow_i, req_eow_i, req_fraction_i, req_scale_i,
        input  req_sign_i, req_zero_i, req_NaR_i, q_rtr_i, res_rts_i, res_rtr_i, res_eow_i,
        output req_rtr_o, q_rts_o, q_sow_o, q_eow_o, q_fraction_o, q_scale_o,
        output q_sign_o, q_zero_o, q_NaR_o, res_id_o, res_id_vld_o, busy_o, proto_err_o
    );

    modport master (
        output req_rts_i, req_sow_i, req_eow_i, req_fraction_i, req_scale_i,
        output req_sign_i, req_zero_i, req_NaR_i, q_rtr_i, res_rts_i, res_rtr_i, res_eow_i,
        input  req_rtr_o, q_rts_o, q_sow_o, q_eow_o, q_fraction_o, q_scale_o,
        input  q_sign_o, q_zero_o, q_NaR_o, res_id_o, res_id_vld_o, busy_o, proto_err_o
    );

endinterface

// File: rtl/quire_window_arbiter_tag_fifo.sv
// quire_window_arbiter_tag_fifo: small synchronous FIFO holding the owner id of each granted window
module quire_window_arbiter_tag_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push, do_pop;

    // Extra pointer msb tells full from empty; pops on empty and pushes on full are dropped
    always_comb begin
        empty    = wr_ptr_q == rd_ptr_q;
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
        head     = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Pointer registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read once the pointers say they are valid
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/quire_window_arbiter.sv
// quire_window_arbiter: round-robin grant of whole sow..eow windows onto one quire, with owner tagging of results
module quire_window_arbiter
    import quire_window_arbiter_pkg::*;
#(
    parameter int NB_REQ    = 4,
    parameter int ID_W      = 2,
    parameter int TAG_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    quire_window_arbiter_if.slave bus
);

    arb_state_t        state_q, state_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic              first_q, first_d;
    logic              err_q, err_d;
    logic [NB_REQ-1:0] elig, req_rtr;
    logic              push, pop, fifo_full, fifo_empty, xfer;
    logic [ID_W-1:0]   fifo_head;
    posit_beat_t       beat;

    // First eligible lane at or after ptr, wrapping at NB_REQ
    function automatic logic [ID_W-1:0] rr_pick(input logic [NB_REQ-1:0] e, input logic [ID_W-1:0] ptr);
        logic [ID_W-1:0] pick;
        int              idx;
        pick = ptr;
        for (int i = NB_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NB_REQ;
            if (e[idx]) pick = ID_W'(idx);
        end
        return pick;
    endfunction

    // Arbitrate in IDLE, forward the granted lane in LOCKED, and flag protocol violations
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        first_d  = first_q;
        err_d    = err_q;
        push     = 1'b0;
        req_rtr  = '0;
        beat     = '0;
        xfer     = 1'b0;
        elig     = bus.req_rts_i & bus.req_sow_i;
        pop      = bus.res_rts_i && bus.res_rtr_i && bus.res_eow_i;
        if (pop && fifo_empty) err_d = 1'b1;
        if (state_q == ST_IDLE) begin
            if (|(bus.req_rts_i & ~bus.req_sow_i)) err_d = 1'b1;
            if (|elig && !fifo_full) begin
                grant_d = rr_pick(elig, rr_ptr_q);
                push    = 1'b1;
                first_d = 1'b1;
                state_d = ST_LOCKED;
            end
        end else begin
            beat.sow         = bus.req_sow_i[grant_q];
            beat.eow         = bus.req_eow_i[grant_q];
            beat.fraction    = bus.req_fraction_i[POSIT_FRAC_W*int'(grant_q) +: POSIT_FRAC_W];
            beat.scale       = bus.req_scale_i[POSIT_SCALE_W*int'(grant_q) +: POSIT_SCALE_W];
            beat.sign        = bus.req_sign_i[grant_q];
            beat.zero        = bus.req_zero_i[grant_q];
            beat.nar         = bus.req_NaR_i[grant_q];
            req_rtr[grant_q] = bus.q_rtr_i;
            xfer             = bus.req_rts_i[grant_q] && bus.q_rtr_i;
            if (xfer) begin
                first_d = 1'b0;
                if (beat.sow && !first_q) err_d = 1'b1;
                if (beat.eow) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = (grant_q == ID_W'(NB_REQ - 1)) ? '0 : grant_q + 1'b1;
                end
            end
        end
    end

    // State and bookkeeping registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            first_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            first_q  <= first_d;
            err_q    <= err_d;
        end
    end

    quire_window_arbiter_tag_fifo #(
        .W     (ID_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (grant_d),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign bus.req_rtr_o    = req_rtr;
    assign bus.q_rts_o      = (state_q == ST_LOCKED) && bus.req_rts_i[grant_q];
    assign bus.q_sow_o      = beat.sow;
    assign bus.q_eow_o      = beat.eow;
    assign bus.q_fraction_o = beat.fraction;
    assign bus.q_scale_o    = beat.scale;
    assign bus.q_sign_o     = beat.sign;
    assign bus.q_zero_o     = beat.zero;
    assign bus.q_NaR_o      = beat.nar;
    assign bus.res_id_o     = fifo_empty ? '0 : fifo_head;
    assign bus.res_id_vld_o = !fifo_empty;
    assign bus.busy_o       = state_q == ST_LOCKED;
    assign bus.proto_err_o  = err_q;

endmodule

// File: tb/tb_quire_window_arbiter.sv
// tb_quire_window_arbiter: directed scenarios for the quire window arbiter
module tb_quire_window_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    quire_window_arbiter_if #(.NB_REQ(4), .ID_W(2)) bus ();

    quire_window_arbiter #(
        .NB_REQ    (4),
        .ID_W      (2),
        .TAG_DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.req_rts_i      = '0;
        bus.req_sow_i      = '0;
        bus.req_eow_i      = '0;
        bus.req_fraction_i = '0;
        bus.req_scale_i    = '0;
        bus.req_sign_i     = '0;
        bus.req_zero_i     = '0;
        bus.req_NaR_i      = '0;
        bus.q_rtr_i        = 1'b0;
        bus.res_rts_i      = 1'b0;
        bus.res_rtr_i      = 1'b0;
        bus.res_eow_i      = 1'b0;
    endtask

    task automatic set_lane(input int k, input logic rts, input logic sow, input logic eow,
                            input logic [3:0] frac, input logic [3:0] scale, input logic [2:0] flags);
        bus.req_rts_i[k]            = rts;
        bus.req_sow_i[k]            = sow;
        bus.req_eow_i[k]            = eow;
        bus.req_fraction_i[4*k +: 4] = frac;
        bus.req_scale_i[4*k +: 4]    = scale;
        bus.req_sign_i[k]           = flags[2];
        bus.req_zero_i[k]           = flags[1];
        bus.req_NaR_i[k]            = flags[0];
    endtask

    task automatic set_res(input logic v);
        bus.res_rts_i = v;
        bus.res_rtr_i = v;
        bus.res_eow_i = v;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        clear_inputs();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        #1;
        checks++; if (bus.req_rtr_o !== 4'b0000) begin failures++; $display("FAIL rst_req_rtr got=%b exp=0000", bus.req_rtr_o); end
        checks++; if (bus.q_rts_o !== 1'b0) begin failures++; $display("FAIL rst_q_rts got=%b exp=0", bus.q_rts_o); end
        checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.busy_o); end
        checks++; if (bus.res_id_vld_o !== 1'b0) begin failures++; $display("FAIL rst_id_vld got=%b exp=0", bus.res_id_vld_o); end
        checks++; if (bus.res_id_o !== 2'd0) begin failures++; $display("FAIL rst_res_id got=%0d exp=0", bus.res_id_o); end
        checks++; if (bus.proto_err_o !== 1'b0) begin failures++; $display("FAIL rst_proto_err got=%b exp=0", bus.proto_err_o); end
    endtask

    task automatic test_single_window;
        do_reset();
        set_lane(2, 1, 1, 0, 4'h5, 4'hE, 3'b101);
        bus.q_rtr_i = 1'b1;
        #1;
        checks++; if (bus.req_rtr_o !== 4'b0000) begin failures++; $display("FAIL win_arb_rtr got=%b exp=0000", bus.req_rtr_o); end
        checks++; if (bus.q_rts_o !== 1'b0) begin failures++; $display("FAIL win_arb_q_rts got=%b exp=0", bus.q_rts_o); end
        step();
        checks++; if (bus.busy_o !== 1'b1) begin failures++; $display("FAIL win_busy got=%b exp=1", bus.busy_o); end
        checks++; if (bus.req_rtr_o !== 4'b0100) begin failures++; $display("FAIL win_rtr got=%b exp=0100", bus.req_rtr_o); end
        checks++; if ({bus.q_rts_o, bus.q_sow_o, bus.q_eow_o} !== 3'b110) begin failures++; $display("FAIL win_b0_ctl got=%b exp=110", {bus.q_rts_o, bus.q_sow_o, bus.q_eow_o}); end
        checks++; if ({bus.q_fraction_o, bus.q_scale_o} !== 8'h5E) begin failures++; $display("FAIL win_b0_data got=%h exp=5e", {bus.q_fraction_o, bus.q_scale_o}); end
        checks++; if ({bus.q_sign_o, bus.q_zero_o, bus.q_NaR_o} !== 3'b101) begin failures++; $display("FAIL win_b0_flags got=%b exp=101", {bus.q_sign_o, bus.q_zero_o, bus.q_NaR_o}); end
        checks++; if ({bus.res_id_vld_o, bus.res_id_o} !== 3'b110) begin failures++; $display("FAIL win_tag got=%b exp=110", {bus.res_id_vld_o, bus.res_id_o}); end
        step();
        set_lane(2, 1, 0, 0, 4'h6, 4'h1, 3'b010);
        #1;
        checks++; if ({bus.q_sow_o, bus.q_eow_o, bus.q_fraction_o} !== 6'b00_0110) begin failures++; $display("FAIL win_b1 got=%b exp=000110", {bus.q_sow_o, bus.q_eow_o, bus.q_fraction_o}); end
        checks++; if ({bus.q_zero_o, bus.q_scale_o} !== 5'b1_0001) begin failures++; $display("FAIL win_b1_zs got=%b exp=10001", {bus.q_zero_o, bus.q_scale_o}); end
        step();
        set_lane(2, 1, 0, 1, 4'h7, 4'h0, 3'b000);
        #1;
        checks++; if ({bus.q_eow_o, bus.q_fraction_o} !== 5'b1_0111) begin failures++; $display("FAIL win_b2 got=%b exp=10111", {bus.q_eow_o, bus.q_fraction_o}); end
        step();
        set_lane(2, 0, 0, 0, 4'h0, 4'h0, 3'b000);
        #1;
        checks++; if ({bus.busy_o, bus.q_rts_o} !== 2'b00) begin failures++; $display("FAIL win_done got=%b exp=00", {bus.busy_o, bus.q_rts_o}); end
        checks++; if ({bus.res_id_vld_o, bus.res_id_o} !== 3'b110) begin failures++; $display("FAIL win_tag_hold got=%b exp=110", {bus.res_id_vld_o, bus.res_id_o}); end
        bus.res_rts_i = 1'b1;
        bus.res_eow_i = 1'b1;
        step();
        checks++; if (bus.res_id_vld_o !== 1'b1) begin failures++; $display("FAIL win_no_retire got=%b exp=1", bus.res_id_vld_o); end
        bus.res_rtr_i = 1'b1;
        step();
        set_res(1'b0);
        #1;
        checks++; if ({bus.res_id_vld_o, bus.res_id_o} !== 3'b000) begin failures++; $display("FAIL win_retired got=%b exp=000", {bus.res_id_vld_o, bus.res_id_o}); end
        set_lane(0, 1, 1, 1, 4'h1, 4'h0, 3'b000);
        set_lane(3, 1, 1, 1, 4'h3, 4'h0, 3'b000);
        step();
        checks++; if ({bus.req_rtr_o, bus.res_id_o} !== 6'b1000_11) begin failures++; $display("FAIL win_rr_ptr got=%b exp=100011", {bus.req_rtr_o, bus.res_id_o}); end
        checks++; if (bus.proto_err_o !== 1'b0) begin failures++; $display("FAIL win_err got=%b exp=0", bus.proto_err_o); end
    endtask

    task automatic test_round_robin;
        do_reset();
        for (int k = 0; k < 4; k++) set_lane(k, 1, 1, 1, 4'(k + 8), 4'h0, 3'b000);
        bus.q_rtr_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if ({bus.busy_o, bus.q_rts_o} !== 2'b00) begin failures++; $display("FAIL rr_idle_gap%0d got=%b exp=00", i, {bus.busy_o, bus.q_rts_o}); end
            step();
            set_res(1'b1);
            #1;
            checks++; if (bus.req_rtr_o !== 4'(1 << (i % 4))) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", i, bus.req_rtr_o, 4'(1 << (i % 4))); end
            checks++; if ({bus.res_id_o, bus.q_fraction_o} !== {2'(i % 4), 4'(i % 4 + 8)}) begin failures++; $display("FAIL rr_data%0d got=%h exp=%h", i, {bus.res_id_o, bus.q_fraction_o}, {2'(i % 4), 4'(i % 4 + 8)}); end
            step();
            set_res(1'b0);
        end
        checks++; if ({bus.proto_err_o, bus.res_id_vld_o} !== 2'b00) begin failures++; $display("FAIL rr_end got=%b exp=00", {bus.proto_err_o, bus.res_id_vld_o}); end
    endtask

    task automatic test_backpressure;
        do_reset();
        set_lane(1, 1, 1, 0, 4'h1, 4'h2, 3'b000);
        set_lane(3, 1, 1, 1, 4'hF, 4'h0, 3'b000);
        bus.q_rtr_i = 1'b1;
        step();
        #1;
        checks++; if ({bus.req_rtr_o, bus.q_fraction_o} !== 8'b0010_0001) begin failures++; $display("FAIL bp_b0 got=%b exp=00100001", {bus.req_rtr_o, bus.q_fraction_o}); end
        step();
        set_lane(1, 1, 0, 0, 4'h2, 4'h2, 3'b000);
        bus.q_rtr_i = 1'b0;
        #1;
        checks++; if ({bus.req_rtr_o, bus.q_rts_o, bus.q_fraction_o} !== 9'b0000_1_0010) begin failures++; $display("FAIL bp_stall got=%b exp=000010010", {bus.req_rtr_o, bus.q_rts_o, bus.q_fraction_o}); end
        step();
        bus.q_rtr_i = 1'b1;
        #1;
        checks++; if ({bus.busy_o, bus.req_rtr_o, bus.q_fraction_o} !== 9'b1_0010_0010) begin failures++; $display("FAIL bp_held got=%b exp=100100010", {bus.busy_o, bus.req_rtr_o, bus.q_fraction_o}); end
        step();
        set_lane(1, 1, 0, 1, 4'h3, 4'h2, 3'b000);
        #1;
        checks++; if ({bus.q_eow_o, bus.q_fraction_o} !== 5'b1_0011) begin failures++; $display("FAIL bp_b2 got=%b exp=10011", {bus.q_eow_o, bus.q_fraction_o}); end
        step();
        set_lane(1, 0, 0, 0, 4'h0, 4'h0, 3'b000);
        #1;
        checks++; if ({bus.busy_o, bus.req_rtr_o} !== 5'b0_0000) begin failures++; $display("FAIL bp_done got=%b exp=00000", {bus.busy_o, bus.req_rtr_o}); end
        step();
        checks++; if ({bus.req_rtr_o, bus.q_fraction_o} !== 8'b1000_1111) begin failures++; $display("FAIL bp_next got=%b exp=10001111", {bus.req_rtr_o, bus.q_fraction_o}); end
    endtask

    task automatic test_fifo_full;
        logic [1:0] drain [4];
        drain[0] = 2'd2; drain[1] = 2'd3; drain[2] = 2'd0; drain[3] = 2'd1;
        do_reset();
        for (int k = 0; k < 4; k++) set_lane(k, 1, 1, 1, 4'h0, 4'h0, 3'b000);
        bus.q_rtr_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (bus.req_rtr_o !== 4'(1 << i)) begin failures++; $display("FAIL full_fill%0d got=%b exp=%b", i, bus.req_rtr_o, 4'(1 << i)); end
            step();
        end
        step();
        checks++; if ({bus.busy_o, bus.req_rtr_o} !== 5'b0_0000) begin failures++; $display("FAIL full_blocked got=%b exp=00000", {bus.busy_o, bus.req_rtr_o}); end
        set_res(1'b1);
        step();
        checks++; if ({bus.busy_o, bus.res_id_o} !== 3'b0_01) begin failures++; $display("FAIL full_retire got=%b exp=001", {bus.busy_o, bus.res_id_o}); end
        step();
        set_res(1'b0);
        #1;
        checks++; if ({bus.busy_o, bus.req_rtr_o, bus.res_id_o} !== 7'b1_0001_10) begin failures++; $display("FAIL full_push_pop got=%b exp=1000110", {bus.busy_o, bus.req_rtr_o, bus.res_id_o}); end
        step();
        step();
        checks++; if ({bus.busy_o, bus.req_rtr_o, bus.res_id_o} !== 7'b1_0010_10) begin failures++; $display("FAIL full_refill got=%b exp=1001010", {bus.busy_o, bus.req_rtr_o, bus.res_id_o}); end
        step();
        step();
        checks++; if ({bus.busy_o, bus.req_rtr_o} !== 5'b0_0000) begin failures++; $display("FAIL full_again got=%b exp=00000", {bus.busy_o, bus.req_rtr_o}); end
        for (int k = 0; k < 4; k++) set_lane(k, 0, 0, 0, 4'h0, 4'h0, 3'b000);
        set_res(1'b1);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if ({bus.res_id_vld_o, bus.res_id_o} !== {1'b1, drain[i]}) begin failures++; $display("FAIL full_drain%0d got=%b exp=%b", i, {bus.res_id_vld_o, bus.res_id_o}, {1'b1, drain[i]}); end
            step();
        end
        checks++; if ({bus.res_id_vld_o, bus.proto_err_o} !== 2'b00) begin failures++; $display("FAIL full_empty got=%b exp=00", {bus.res_id_vld_o, bus.proto_err_o}); end
        step();
        set_res(1'b0);
        #1;
        checks++; if ({bus.res_id_vld_o, bus.proto_err_o} !== 2'b01) begin failures++; $display("FAIL full_pop_empty got=%b exp=01", {bus.res_id_vld_o, bus.proto_err_o}); end
    endtask

    task automatic test_proto_err;
        do_reset();
        set_lane(0, 1, 0, 0, 4'h4, 4'h0, 3'b000);
        bus.q_rtr_i = 1'b1;
        #1;
        checks++; if (bus.req_rtr_o !== 4'b0000) begin failures++; $display("FAIL perr_rtr got=%b exp=0000", bus.req_rtr_o); end
        step();
        checks++; if ({bus.proto_err_o, bus.busy_o, bus.req_rtr_o} !== 6'b10_0000) begin failures++; $display("FAIL perr_nosow got=%b exp=100000", {bus.proto_err_o, bus.busy_o, bus.req_rtr_o}); end
        step();
        checks++; if ({bus.proto_err_o, bus.busy_o} !== 2'b10) begin failures++; $display("FAIL perr_sticky got=%b exp=10", {bus.proto_err_o, bus.busy_o}); end
        do_reset();
        #1;
        checks++; if (bus.proto_err_o !== 1'b0) begin failures++; $display("FAIL perr_cleared got=%b exp=0", bus.proto_err_o); end
        set_lane(2, 1, 1, 0, 4'h1, 4'h0, 3'b000);
        bus.q_rtr_i = 1'b1;
        step();
        step();
        set_lane(2, 1, 1, 1, 4'h9, 4'h0, 3'b000);
        #1;
        checks++; if ({bus.q_rts_o, bus.q_sow_o, bus.q_fraction_o, bus.proto_err_o} !== 7'b11_1001_0) begin failures++; $display("FAIL perr_midsow_fwd got=%b exp=1110010", {bus.q_rts_o, bus.q_sow_o, bus.q_fraction_o, bus.proto_err_o}); end
        step();
        set_lane(2, 0, 0, 0, 4'h0, 4'h0, 3'b000);
        #1;
        checks++; if ({bus.proto_err_o, bus.busy_o} !== 2'b10) begin failures++; $display("FAIL perr_midsow got=%b exp=10", {bus.proto_err_o, bus.busy_o}); end
    endtask

    task automatic test_reset_mid_window;
        do_reset();
        set_lane(1, 1, 1, 0, 4'h1, 4'h0, 3'b000);
        bus.q_rtr_i = 1'b1;
        step();
        step();
        set_lane(1, 1, 0, 0, 4'h2, 4'h0, 3'b000);
        step();
        set_lane(1, 1, 0, 0, 4'h3, 4'h0, 3'b000);
        #1;
        checks++; if ({bus.busy_o, bus.q_fraction_o} !== 5'b1_0011) begin failures++; $display("FAIL mid_pre got=%b exp=10011", {bus.busy_o, bus.q_fraction_o}); end
        rst_n = 1'b0;
        clear_inputs();
        step();
        checks++; if ({bus.busy_o, bus.q_rts_o, bus.req_rtr_o} !== 6'b00_0000) begin failures++; $display("FAIL mid_rst_ctl got=%b exp=000000", {bus.busy_o, bus.q_rts_o, bus.req_rtr_o}); end
        checks++; if ({bus.res_id_vld_o, bus.res_id_o, bus.proto_err_o} !== 4'b0_00_0) begin failures++; $display("FAIL mid_rst_tag got=%b exp=0000", {bus.res_id_vld_o, bus.res_id_o, bus.proto_err_o}); end
        rst_n = 1'b1;
        set_lane(3, 1, 1, 1, 4'hA, 4'h0, 3'b000);
        bus.q_rtr_i = 1'b1;
        step();
        checks++; if ({bus.busy_o, bus.req_rtr_o, bus.res_id_vld_o, bus.res_id_o} !== 8'b1_1000_1_11) begin failures++; $display("FAIL mid_regrant got=%b exp=11000111", {bus.busy_o, bus.req_rtr_o, bus.res_id_vld_o, bus.res_id_o}); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_window();
        test_round_robin();
        test_backpressure();
        test_fifo_full();
        test_proto_err();
        test_reset_mid_window();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
